// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU command sequencer.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_WAIT = 2'b10,
    S_RESP = 2'b11
  } state_e;

  // ALU in_sel is {persist, load, reset}; all-zero only while held in reset.
  localparam logic [2:0] IN_OFF     = 3'b000;
  localparam logic [2:0] IN_PERSIST = 3'b100;
  localparam logic [2:0] IN_LOAD    = 3'b010;
  localparam logic [2:0] IN_RESET   = 3'b001;

  localparam logic [2:0] OP_CLEAR = 3'd7;

  // Bit k of the one-hot out_sel: op n lights bit (num_ops-1-n), so op0 is the MSB.
  // The clear op lights nothing.
  function automatic logic op_sel_bit(input logic [2:0] op, input int num_ops, input int k);
    return (op != OP_CLEAR) && (int'(op) == num_ops - 1 - k);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Small synchronous command FIFO with full/empty flags and show-ahead read data.
module alu_cmd_fifo #(
  parameter int DW    = 19,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          pop_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Drives the ALU operand/select interface from a queue of commands and returns
// each captured ALU result over a valid/ready handshake.
//
// state  | meaning
// IDLE   | waiting for a queued command; ALU told to persist
// LOAD   | one cycle presenting operands/op with in_sel=load (reset for clear)
// WAIT   | ALU_LAT cycles for the ALU result; capture on the last one
// RESP   | result held until res_ready; then next command or IDLE
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int NUM_OPS    = 7,
  parameter int ALU_LAT    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [WIDTH-1:0]   cmd_a,
  input  logic [WIDTH-1:0]   cmd_b,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [WIDTH-1:0]   res_data,
  output logic [2:0]         res_op,
  output logic               alu_on,
  output logic [2:0]         alu_in_sel,
  output logic [WIDTH-1:0]   alu_num1,
  output logic [WIDTH-1:0]   alu_num2,
  output logic [NUM_OPS-1:0] alu_out_sel,
  input  logic [WIDTH-1:0]   alu_out,
  output logic [1:0]         state
);

  localparam int FW = 2*WIDTH + 3;

  logic [FW-1:0]      fifo_rdata;
  logic               fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [2:0]         head_op;
  logic [WIDTH-1:0]   head_a, head_b;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   num1_q, num1_d, num2_q, num2_d;
  logic [NUM_OPS-1:0] sel_q, sel_d;
  logic [WIDTH-1:0]   res_data_q, res_data_d;
  logic [2:0]         res_op_q, res_op_d;
  logic               alu_on_q;

  assign cmd_ready = rst && !fifo_full;
  assign fifo_push = cmd_valid && cmd_ready;
  assign {head_op, head_a, head_b} = fifo_rdata;

  alu_cmd_fifo #(
    .DW    (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .wdata_i ({cmd_op, cmd_a, cmd_b}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Next-state, pop decision, ALU select and result capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    num1_d     = num1_q;
    num2_d     = num2_q;
    sel_d      = sel_q;
    res_data_d = res_data_q;
    res_op_d   = res_op_q;
    fifo_pop   = 1'b0;
    alu_in_sel = alu_on_q ? IN_PERSIST : IN_OFF;

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        alu_in_sel = (op_q == OP_CLEAR) ? IN_RESET : IN_LOAD;
        cnt_d      = 4'(ALU_LAT);
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          res_data_d = (op_q == OP_CLEAR) ? '0 : alu_out;
          res_op_d   = op_q;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        if (res_ready) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = S_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Operands and op select change only when a command is popped, so they
    // stay stable through WAIT and keep their last values in IDLE/RESP.
    if (fifo_pop) begin
      op_d   = head_op;
      num1_d = head_a;
      num2_d = head_b;
      for (int k = 0; k < NUM_OPS; k++) sel_d[k] = op_sel_bit(head_op, NUM_OPS, k);
    end
  end

  // State and datapath registers; reset drops any in-flight or held result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      num1_q     <= '0;
      num2_q     <= '0;
      sel_q      <= '0;
      res_data_q <= '0;
      res_op_q   <= '0;
      alu_on_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      num1_q     <= num1_d;
      num2_q     <= num2_d;
      sel_q      <= sel_d;
      res_data_q <= res_data_d;
      res_op_q   <= res_op_d;
      alu_on_q   <= 1'b1;
    end
  end

  assign state       = state_q;
  assign res_valid   = (state_q == S_RESP);
  assign res_data    = res_data_q;
  assign res_op      = res_op_q;
  assign alu_on      = alu_on_q;
  assign alu_num1    = num1_q;
  assign alu_num2    = num2_q;
  assign alu_out_sel = sel_q;

endmodule
